// File: rtl/crc_pkg.sv
`default_nettype none
// ============================================================================
// Module   : crc_pkg
// Purpose  : Shared constants, FSM state type and the LFSR payload-update
//            function for the serial CRC checker and its LFSR core.
// Contents : N (CRC width), TAPS (tap mask), SEED (frame-start value),
//            CNT_W (CRC bit / error counter width), state_t, lfsr_update().
// Revision : 1.0 - initial release
// ============================================================================
package crc_pkg;

  localparam int             N     = 8;
  localparam logic [N-1:0]   TAPS  = 8'b01000100;
  localparam logic [N-1:0]   SEED  = 8'hD8;
  localparam int             CNT_W = $clog2(N + 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DATA   = 2'd1,
    CHECK  = 2'd2,
    REPORT = 2'd3
  } state_t;

  // One payload step: the bit leaving LFSR[0] is mixed with the data bit to
  // form the feedback, which enters at the top and is folded into every
  // tapped position on the way down.
  function automatic logic [N-1:0] lfsr_update(input logic [N-1:0] cur,
                                               input logic         din);
    logic fb;
    fb          = cur[0] ^ din;
    lfsr_update = {fb, cur[N-1:1] ^ (TAPS[N-2:0] & {(N-1){fb}})};
  endfunction

endpackage
`default_nettype wire

// File: rtl/crc_lfsr_core.sv
`default_nettype none
// ============================================================================
// Module   : crc_lfsr_core
// Purpose  : Feedback/tap shift register shared by the serial CRC generator
//            and checker. Can reload SEED, absorb one payload bit, or shift
//            the remainder out LSB-first.
// Ports    : CLK       in  1  clock, rising edge
//            RST       in  1  synchronous active-high reset (LFSR <= SEED)
//            load_seed in  1  start from SEED this cycle (combines with
//                             step/shift_out, which then act on SEED)
//            step      in  1  absorb data_bit (has priority over shift_out)
//            data_bit  in  1  payload bit used by step
//            shift_out in  1  shift right by one, zero fill
//            lfsr      out N  current register contents
// Revision : 1.0 - initial release
// ============================================================================
module crc_lfsr_core
  import crc_pkg::*;
(
  input  logic         CLK,
  input  logic         RST,
  input  logic         load_seed,
  input  logic         step,
  input  logic         data_bit,
  input  logic         shift_out,
  output logic [N-1:0] lfsr
);

  logic [N-1:0] r_lfsr;
  logic [N-1:0] w_base;
  logic [N-1:0] w_next;

  always_comb begin
    w_base = load_seed ? SEED : r_lfsr;
    if (step) begin
      w_next = lfsr_update(w_base, data_bit);
    end else if (shift_out) begin
      w_next = w_base >> 1;
    end else begin
      w_next = w_base;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_lfsr <= SEED;
    end else begin
      r_lfsr <= w_next;
    end
  end

  assign lfsr = r_lfsr;

endmodule
`default_nettype wire

// File: rtl/crc_checker.sv
`default_nettype none
// ============================================================================
// Module   : crc_checker
// Purpose  : Receive-side serial CRC checker. Recomputes the CRC over the
//            payload with the shared LFSR core, compares the N serial CRC
//            bits that follow, and reports one verdict per frame.
// Ports    : CLK       in  1      clock, rising edge
//            RST       in  1      synchronous active-high reset
//            Data      in  1      payload bit, sampled when ACTIVE=1
//            ACTIVE    in  1      payload bit strobe
//            CRC_In    in  1      received CRC bit, sampled when CRC_Valid=1
//            CRC_Valid in  1      CRC bit strobe
//            Done      out 1      one-cycle verdict pulse
//            Match     out 1      frame CRC correct (held to next frame)
//            Error     out 1      CRC wrong or frame aborted (held)
//            Err_Cnt   out CNT_W  mismatching CRC bits in last frame (held)
// Revision : 1.0 - initial release
// ============================================================================
module crc_checker
  import crc_pkg::*;
(
  input  logic             CLK,
  input  logic             RST,
  input  logic             Data,
  input  logic             ACTIVE,
  input  logic             CRC_In,
  input  logic             CRC_Valid,
  output logic             Done,
  output logic             Match,
  output logic             Error,
  output logic [CNT_W-1:0] Err_Cnt
);

  localparam logic             c_seed_lsb = SEED[0];
  localparam logic [CNT_W-1:0] c_last_idx = CNT_W'(N - 1);
  localparam logic [CNT_W-1:0] c_err_max  = CNT_W'(N);

  state_t r_state;
  state_t w_state_nxt;

  // Control strobes decoded from state and inputs
  logic w_load;    // reload SEED (frame start)
  logic w_step;    // absorb payload bit
  logic w_shift;   // shift one CRC bit out of the LFSR
  logic w_cmp;     // compare CRC_In against LFSR[0]
  logic w_start;   // frame start: clear flags and counters
  logic w_abort;   // payload strobe during CRC phase
  logic w_report;  // publish verdict

  logic [N-1:0]     w_lfsr;
  logic             w_ref_bit;
  logic             w_mismatch;
  logic [CNT_W-1:0] w_cnt_base;
  logic [CNT_W-1:0] w_err_base;
  logic [CNT_W-1:0] w_bit_cnt_nxt;
  logic [CNT_W-1:0] w_err_cnt_nxt;
  logic             w_last;

  logic [CNT_W-1:0] r_bit_cnt;
  logic [CNT_W-1:0] r_err_cnt;
  logic             r_done;
  logic             r_match;
  logic             r_error;

  crc_lfsr_core u_lfsr (
    .CLK       (CLK),
    .RST       (RST),
    .load_seed (w_load),
    .step      (w_step),
    .data_bit  (Data),
    .shift_out (w_shift),
    .lfsr      (w_lfsr)
  );

  // --------------------------------------------------------------------------
  // State register
  // --------------------------------------------------------------------------
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // --------------------------------------------------------------------------
  // Next-state logic
  // --------------------------------------------------------------------------
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE: begin
        if (ACTIVE)         w_state_nxt = DATA;
        else if (CRC_Valid) w_state_nxt = w_last ? REPORT : CHECK;
      end
      DATA: begin
        if (!ACTIVE && CRC_Valid) w_state_nxt = w_last ? REPORT : CHECK;
      end
      CHECK: begin
        if (ACTIVE)                   w_state_nxt = IDLE;
        else if (CRC_Valid && w_last) w_state_nxt = REPORT;
      end
      REPORT:  w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  // --------------------------------------------------------------------------
  // Output / control decode
  // --------------------------------------------------------------------------
  always_comb begin
    w_load   = 1'b0;
    w_step   = 1'b0;
    w_shift  = 1'b0;
    w_cmp    = 1'b0;
    w_start  = 1'b0;
    w_abort  = 1'b0;
    w_report = 1'b0;
    case (r_state)
      IDLE: begin
        if (ACTIVE) begin
          w_load  = 1'b1;
          w_step  = 1'b1;
          w_start = 1'b1;
        end else if (CRC_Valid) begin
          // Zero-length payload: the first CRC bit is checked against SEED.
          w_load  = 1'b1;
          w_shift = 1'b1;
          w_cmp   = 1'b1;
          w_start = 1'b1;
        end
      end
      DATA: begin
        if (ACTIVE) begin
          w_step = 1'b1;
        end else if (CRC_Valid) begin
          w_shift = 1'b1;
          w_cmp   = 1'b1;
        end
      end
      CHECK: begin
        if (ACTIVE) begin
          w_abort = 1'b1;
        end else if (CRC_Valid) begin
          w_shift = 1'b1;
          w_cmp   = 1'b1;
        end
      end
      REPORT:  w_report = 1'b1;
      default: ;
    endcase
  end

  // --------------------------------------------------------------------------
  // Compare datapath: counters restart from zero on the frame-start cycle so
  // a zero-length frame can compare its first bit in the same cycle.
  // --------------------------------------------------------------------------
  always_comb begin
    w_ref_bit  = w_load ? c_seed_lsb : w_lfsr[0];
    w_mismatch = CRC_In ^ w_ref_bit;
    w_cnt_base = w_start ? '0 : r_bit_cnt;
    w_err_base = w_start ? '0 : r_err_cnt;
    w_last     = (w_cnt_base == c_last_idx);

    w_bit_cnt_nxt = w_cnt_base;
    w_err_cnt_nxt = w_err_base;
    if (w_cmp) begin
      w_bit_cnt_nxt = w_cnt_base + CNT_W'(1);
      if (w_err_base != c_err_max) begin
        w_err_cnt_nxt = w_err_base + CNT_W'(w_mismatch);
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_bit_cnt <= '0;
      r_err_cnt <= '0;
      r_done    <= 1'b0;
      r_match   <= 1'b0;
      r_error   <= 1'b0;
    end else begin
      r_bit_cnt <= w_bit_cnt_nxt;
      r_err_cnt <= w_err_cnt_nxt;
      r_done    <= 1'b0;
      if (w_start) begin
        r_match <= 1'b0;
        r_error <= 1'b0;
      end
      if (w_abort) begin
        r_done  <= 1'b1;
        r_match <= 1'b0;
        r_error <= 1'b1;
      end
      if (w_report) begin
        r_done  <= 1'b1;
        r_match <= (r_err_cnt == '0);
        r_error <= (r_err_cnt != '0);
      end
    end
  end

  assign Done    = r_done;
  assign Match   = r_match;
  assign Error   = r_error;
  assign Err_Cnt = r_err_cnt;

endmodule
`default_nettype wire

// File: tb/tb_crc_checker.sv
`default_nettype none
// ============================================================================
// Module   : tb_crc_checker
// Purpose  : Self-checking bench for crc_checker. Frames are built from a
//            payload queue; the expected CRC is computed by a Galois-LFSR
//            reference written directly from the polynomial rules.
// Revision : 1.0 - initial release
// ============================================================================
module tb_crc_checker;

  localparam int          W      = 8;
  localparam int          CW     = 4;
  localparam logic [W-1:0] C_SEED = 8'hD8;
  localparam logic [W-1:0] C_TAPS = 8'b01000100;
  // Feedback enters bit W-1 and is xored into every tapped lower bit.
  localparam logic [W-1:0] C_POLY = 8'h80 | (C_TAPS & 8'h7F);

  logic          CLK = 1'b0;
  logic          RST;
  logic          Data;
  logic          ACTIVE;
  logic          CRC_In;
  logic          CRC_Valid;
  logic          Done;
  logic          Match;
  logic          Error;
  logic [CW-1:0] Err_Cnt;

  int n_assert = 0;
  int n_fail   = 0;
  bit payload[$];

  crc_checker dut (
    .CLK       (CLK),
    .RST       (RST),
    .Data      (Data),
    .ACTIVE    (ACTIVE),
    .CRC_In    (CRC_In),
    .CRC_Valid (CRC_Valid),
    .Done      (Done),
    .Match     (Match),
    .Error     (Error),
    .Err_Cnt   (Err_Cnt)
  );

  always #5 CLK = ~CLK;

  function automatic logic [W-1:0] model_crc();
    logic [W-1:0] r;
    logic         fb;
    r = C_SEED;
    foreach (payload[i]) begin
      fb = r[0] ^ payload[i];
      r  = (r >> 1) ^ (fb ? C_POLY : '0);
    end
    return r;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic idle();
    ACTIVE    = 1'b0;
    CRC_Valid = 1'b0;
    Data      = 1'b0;
    CRC_In    = 1'b0;
  endtask

  task automatic maybe_gap(input int pct);
    for (int g = 0; g < 3; g++) begin
      if ($urandom_range(99) >= pct) break;
      idle();
      tick();
    end
  endtask

  task automatic send_payload(input int pct);
    foreach (payload[i]) begin
      if (i > 0) maybe_gap(pct);
      ACTIVE = 1'b1;
      Data   = payload[i];
      tick();
    end
    idle();
  endtask

  task automatic send_crc_bits(input logic [W-1:0] sent, input int nbits, input int pct);
    for (int i = 0; i < nbits; i++) begin
      maybe_gap(pct);
      CRC_Valid = 1'b1;
      CRC_In    = sent[i];
      tick();
      idle();
    end
  endtask

  // Full frame; verdict must appear exactly on the second edge after the last
  // CRC bit (one edge in REPORT, then visible for one cycle).
  task automatic run_frame(input string tag, input logic [W-1:0] sent, input int exp_err,
                           input int pct, input bit tail);
    send_payload(pct);
    send_crc_bits(sent, W, pct);
    check({tag, ".done_early"}, Done, 0);
    tick();
    check({tag, ".done"},    Done, 1);
    check({tag, ".match"},   Match, (exp_err == 0));
    check({tag, ".error"},   Error, (exp_err != 0));
    check({tag, ".err_cnt"}, Err_Cnt, exp_err);
    if (tail) begin
      tick();
      check({tag, ".done_clr"},   Done, 0);
      check({tag, ".match_held"}, Match, (exp_err == 0));
    end
  endtask

  task automatic rand_payload(input int len);
    payload.delete();
    for (int i = 0; i < len; i++) payload.push_back(1'($urandom_range(1)));
  endtask

  initial begin
    logic [W-1:0] crc;
    logic [W-1:0] flip;

    // Reset
    RST = 1'b1;
    idle();
    tick();
    tick();
    check("rst.done",    Done, 0);
    check("rst.match",   Match, 0);
    check("rst.error",   Error, 0);
    check("rst.err_cnt", Err_Cnt, 0);
    RST = 1'b0;
    tick();

    // 1. Zero-length payload: CRC equals SEED
    payload.delete();
    run_frame("t1_zero", 8'hD8, 0, 0, 1'b1);

    // 2. Single-bit payloads
    payload = {1'b0};
    run_frame("t2_bit0", 8'h6C, 0, 0, 1'b1);
    payload = {1'b1};
    run_frame("t2_bit1", 8'hA8, 0, 0, 1'b1);

    // 3. Two flipped CRC bits
    payload = {1'b1};
    run_frame("t3_flip", 8'hA8 ^ 8'h81, 2, 0, 1'b1);

    // 4. Gaps give the same verdict
    rand_payload(16);
    crc = model_crc();
    run_frame("t4_nogap", crc, 0, 0, 1'b1);
    run_frame("t4_gap", crc, 0, 60, 1'b1);
    run_frame("t4_gap_bad", crc ^ 8'h10, 1, 60, 1'b1);

    // 5. Abort after three CRC bits, then a clean frame
    rand_payload(5);
    crc = model_crc();
    send_payload(0);
    send_crc_bits(crc, 3, 0);
    ACTIVE = 1'b1;
    Data   = 1'b1;
    tick();
    idle();
    check("t5_abort.done",  Done, 1);
    check("t5_abort.error", Error, 1);
    check("t5_abort.match", Match, 0);
    tick();
    check("t5_abort.done_clr",   Done, 0);
    check("t5_abort.error_held", Error, 1);
    rand_payload(7);
    run_frame("t5_clean", model_crc(), 0, 0, 1'b1);

    // 6. Reset mid-CRC discards the frame
    rand_payload(9);
    crc = model_crc();
    send_payload(0);
    send_crc_bits(crc, 4, 0);
    RST = 1'b1;
    tick();
    RST = 1'b0;
    check("t6_rst.done",    Done, 0);
    check("t6_rst.match",   Match, 0);
    check("t6_rst.error",   Error, 0);
    check("t6_rst.err_cnt", Err_Cnt, 0);
    tick();
    check("t6_rst.no_done1", Done, 0);
    tick();
    check("t6_rst.no_done2", Done, 0);
    payload = {1'b0};
    run_frame("t6_seed", 8'h6C, 0, 0, 1'b1);

    // Back-to-back frames with a single idle cycle between them
    rand_payload(6);
    run_frame("t6_b2b_a", model_crc() ^ 8'h03, 2, 0, 1'b0);
    rand_payload(11);
    run_frame("t6_b2b_b", model_crc(), 0, 0, 1'b1);
    payload.delete();
    run_frame("t6_b2b_c", C_SEED, 0, 0, 1'b0);
    payload.delete();
    run_frame("t6_b2b_d", C_SEED ^ 8'hFF, 8, 0, 1'b1);

    // Randomized frames
    for (int f = 0; f < 24; f++) begin
      rand_payload($urandom_range(0, 24));
      flip = ($urandom_range(1) == 0) ? 8'h00 : 8'($urandom_range(255));
      run_frame($sformatf("rnd%0d", f), model_crc() ^ flip, $countones(flip),
                $urandom_range(0, 50), 1'b1);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
